// File: rtl/fib_req_ctrl.sv
// Valid/ready request/response front-end for the fib core: one request in flight,
// launches the core with a single go pulse, captures result/overflow or reports a timeout.
module fib_req_ctrl #(
  parameter int INPUT_WIDTH    = 6,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [INPUT_WIDTH-1:0]  req_n,
  output logic                    fib_go,
  output logic [INPUT_WIDTH-1:0]  fib_n,
  input  logic [OUTPUT_WIDTH-1:0] fib_result,
  input  logic                    fib_overflow,
  input  logic                    fib_done,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [INPUT_WIDTH-1:0]  rsp_n,
  output logic [OUTPUT_WIDTH-1:0] rsp_result,
  output logic                    rsp_overflow,
  output logic                    rsp_timeout
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_CLEAR, WAIT_DONE, RESPOND} state_t;

  state_t                  state_q, state_d;
  logic [INPUT_WIDTH-1:0]  n_q, n_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    go_q, go_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [INPUT_WIDTH-1:0]  rsp_n_q, rsp_n_d;
  logic [OUTPUT_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                    rsp_overflow_q, rsp_overflow_d;
  logic                    rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    tmo_d          = tmo_q;
    go_d           = 1'b0;
    req_ready_d    = req_ready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_n_d        = rsp_n_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_timeout_d  = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          n_d         = req_n;
          go_d        = 1'b1;
          req_ready_d = 1'b0;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT_CLEAR;
      end
      WAIT_CLEAR, WAIT_DONE: begin
        if (tmo_q != TMO_LAST) tmo_d = tmo_q + TW'(1);
        // A done from the previous run is still visible in WAIT_CLEAR, so only
        // WAIT_DONE may capture; done on the expiry cycle beats the timeout.
        if (state_q == WAIT_DONE && fib_done) begin
          rsp_result_d   = fib_result;
          rsp_overflow_d = fib_overflow;
          rsp_n_d        = n_q;
          rsp_timeout_d  = 1'b0;
          rsp_valid_d    = 1'b1;
          state_d        = RESPOND;
        end else if (tmo_q == TMO_LAST) begin
          rsp_result_d   = '0;
          rsp_overflow_d = fib_overflow;
          rsp_n_d        = n_q;
          rsp_timeout_d  = 1'b1;
          rsp_valid_d    = 1'b1;
          state_d        = RESPOND;
        end else if (state_q == WAIT_CLEAR && !fib_done) begin
          state_d = WAIT_DONE;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      n_q            <= '0;
      tmo_q          <= '0;
      go_q           <= 1'b0;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_n_q        <= '0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      tmo_q          <= tmo_d;
      go_q           <= go_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_n_q        <= rsp_n_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_timeout_q  <= rsp_timeout_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign fib_go       = go_q;
  assign fib_n        = n_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_n        = rsp_n_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_timeout  = rsp_timeout_q;

endmodule

// File: tb/tb_fib_req_ctrl.sv
// Directed bench for fib_req_ctrl with a small behavioural fib core model.
module tb_fib_req_ctrl;
  localparam int IW  = 6;
  localparam int OW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_n = '0;
  logic          fib_go;
  logic [IW-1:0] fib_n;
  logic [OW-1:0] fib_result;
  logic          fib_overflow;
  logic          fib_done;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [IW-1:0] rsp_n;
  logic [OW-1:0] rsp_result;
  logic          rsp_overflow;
  logic          rsp_timeout;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int go_cnt = 0;
  logic core_hang = 1'b0;

  fib_req_ctrl #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .fib_go(fib_go), .fib_n(fib_n),
    .fib_result(fib_result), .fib_overflow(fib_overflow), .fib_done(fib_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_n(rsp_n),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  // Core model: done drops the edge after go, rises 3 edges later; sticky overflow.
  function automatic longint unsigned fib_calc(input int n);
    longint unsigned a = 0, b = 1, t;
    for (int i = 0; i < n; i++) begin
      t = a + b; a = b; b = t;
    end
    return a;
  endfunction

  logic [IW-1:0]   core_n;
  int              core_lat;
  logic            core_busy;
  longint unsigned core_val;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fib_done <= 1'b0; fib_overflow <= 1'b0; fib_result <= '0;
      core_busy <= 1'b0; core_lat <= 0; core_n <= '0;
    end else if (fib_go) begin
      fib_done <= 1'b0; core_busy <= 1'b1; core_lat <= 3; core_n <= fib_n;
    end else if (core_busy && !core_hang) begin
      if (core_lat > 1) core_lat <= core_lat - 1;
      else begin
        core_val = fib_calc(int'(core_n));
        fib_result <= OW'(core_val);
        if (core_val >= 64'h1_0000_0000) fib_overflow <= 1'b1;
        fib_done  <= 1'b1;
        core_busy <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fib_go) go_cnt <= go_cnt + 1;
  end

  task automatic send(input logic [IW-1:0] n, input bit hold);
    int k = 0;
    @(negedge clk); req_valid = 1'b1; req_n = n;
    while (!req_ready && k < 300) begin @(negedge clk); k++; end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL send_accept n=%0d: req_ready=%b, required 1", n, req_ready);
    end
    @(posedge clk);
    if (!hold) begin #1 req_valid = 1'b0; end
  endtask

  task automatic recv(input bit keep, output logic [IW-1:0] n, output logic [OW-1:0] r,
                      output logic o, output logic t);
    int k = 0;
    @(negedge clk); rsp_ready = 1'b1;
    while (!rsp_valid && k < 300) begin @(negedge clk); k++; end
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++; $display("FAIL recv_wait: rsp_valid=%b, required 1", rsp_valid);
    end
    n = rsp_n; r = rsp_result; o = rsp_overflow; t = rsp_timeout;
    @(posedge clk);
    if (!keep) begin #1 rsp_ready = 1'b0; end
  endtask

  task automatic chk_rsp(input string nm, input logic [IW-1:0] n, input logic [OW-1:0] r,
                         input logic o, input logic t, input logic [IW-1:0] en,
                         input logic [OW-1:0] er, input logic eo, input logic et);
    tests++;
    if (n !== en || r !== er || o !== eo || t !== et) begin
      fails++;
      $display("FAIL %s: got n=%0d res=%0d ovf=%b tmo=%b, required n=%0d res=%0d ovf=%b tmo=%b",
               nm, n, r, o, t, en, er, eo, et);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if (fib_go !== 1'b0 || fib_n !== '0 || rsp_valid !== 1'b0 || rsp_n !== '0 ||
        rsp_result !== '0 || rsp_overflow !== 1'b0 || rsp_timeout !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: go=%b n=%0d rv=%b rn=%0d res=%0d ovf=%b tmo=%b rdy=%b, required zeros with rdy=1",
               fib_go, fib_n, rsp_valid, rsp_n, rsp_result, rsp_overflow, rsp_timeout, req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [IW-1:0] n; logic [OW-1:0] r; logic o, t;
    int g0 = go_cnt, k = 0;
    send(6'd10, 1'b0);
    @(negedge clk);
    tests++;
    if (fib_go !== 1'b1 || fib_n !== 6'd10) begin
      fails++; $display("FAIL t1_go: go=%b fib_n=%0d, required 1 and 10", fib_go, fib_n);
    end
    while (fib_done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL t1_early_valid: rsp_valid=%b, required 0", rsp_valid);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++; $display("FAIL t1_latency: rsp_valid=%b one cycle after done, required 1", rsp_valid);
    end
    tests++;
    if (fib_n !== 6'd10) begin
      fails++; $display("FAIL t1_fib_n_held: fib_n=%0d, required 10", fib_n);
    end
    recv(1'b0, n, r, o, t);
    chk_rsp("t1_rsp", n, r, o, t, 6'd10, 32'd55, 1'b0, 1'b0);
    tests++;
    if (go_cnt - g0 !== 1) begin
      fails++; $display("FAIL t1_go_count: got %0d pulses, required 1", go_cnt - g0);
    end
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] n[3]; logic [OW-1:0] r[3]; logic o[3], t[3];
    int g0 = go_cnt;
    fork
      begin
        send(6'd0, 1'b1); send(6'd1, 1'b1); send(6'd2, 1'b1);
        #1 req_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 3; i++) recv(1'b1, n[i], r[i], o[i], t[i]);
        #1 rsp_ready = 1'b0;
      end
    join
    chk_rsp("t2_rsp0", n[0], r[0], o[0], t[0], 6'd0, 32'd0, 1'b0, 1'b0);
    chk_rsp("t2_rsp1", n[1], r[1], o[1], t[1], 6'd1, 32'd1, 1'b0, 1'b0);
    chk_rsp("t2_rsp2", n[2], r[2], o[2], t[2], 6'd2, 32'd1, 1'b0, 1'b0);
    tests++;
    if (go_cnt - g0 !== 3) begin
      fails++; $display("FAIL t2_go_count: got %0d pulses, required 3", go_cnt - g0);
    end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] n; logic [OW-1:0] r; logic o, t;
    int g0, k = 0;
    send(6'd20, 1'b0);
    while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_n = 6'd3;
    g0 = go_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd6765 || rsp_n !== 6'd20 || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL t3_hold[%0d]: rv=%b res=%0d n=%0d rdy=%b, required 1/6765/20/0",
                 i, rsp_valid, rsp_result, rsp_n, req_ready);
      end
    end
    tests++;
    if (go_cnt !== g0) begin
      fails++; $display("FAIL t3_no_go: got %0d pulses while stalled, required 0", go_cnt - g0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (fib_go !== 1'b1 || fib_n !== 6'd3) begin
      fails++; $display("FAIL t3_next_go: go=%b fib_n=%0d, required 1 and 3", fib_go, fib_n);
    end
    recv(1'b0, n, r, o, t);
    chk_rsp("t3_next_rsp", n, r, o, t, 6'd3, 32'd2, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    logic [IW-1:0] n; logic [OW-1:0] r; logic o, t;
    send(6'd50, 1'b0);
    recv(1'b0, n, r, o, t);
    chk_rsp("t4_f50", n, r, o, t, 6'd50, 32'd3996334433, 1'b1, 1'b0);
    send(6'd5, 1'b0);
    recv(1'b0, n, r, o, t);
    chk_rsp("t4_sticky", n, r, o, t, 6'd5, 32'd5, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int g, rc, k = 0;
    core_hang = 1'b1;
    send(6'd30, 1'b0);
    @(negedge clk);
    g = cyc;
    tests++;
    if (fib_go !== 1'b1) begin
      fails++; $display("FAIL t5_go: go=%b, required 1", fib_go);
    end
    while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
    rc = cyc;
    tests++;
    if (rc - g !== 17) begin
      fails++; $display("FAIL t5_latency: rsp_valid %0d cycles after go, required 17", rc - g);
    end
    chk_rsp("t5_rsp", rsp_n, rsp_result, rsp_overflow, rsp_timeout, 6'd30, 32'd0, 1'b1, 1'b1);
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    core_hang = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic [IW-1:0] n; logic [OW-1:0] r; logic o, t;
    int g0;
    send(6'd9, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (fib_go !== 1'b0 || fib_n !== '0 || rsp_valid !== 1'b0 || rsp_n !== '0 ||
        rsp_result !== '0 || rsp_overflow !== 1'b0 || rsp_timeout !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL t6_async_reset: go=%b n=%0d rv=%b rn=%0d res=%0d ovf=%b tmo=%b rdy=%b, required zeros with rdy=1",
               fib_go, fib_n, rsp_valid, rsp_n, rsp_result, rsp_overflow, rsp_timeout, req_ready);
    end
    @(negedge clk); rst = 1'b0;
    g0 = go_cnt;
    repeat (5) @(negedge clk);
    tests++;
    if (go_cnt !== g0) begin
      fails++; $display("FAIL t6_spurious_go: got %0d pulses after reset, required 0", go_cnt - g0);
    end
    send(6'd7, 1'b0);
    recv(1'b0, n, r, o, t);
    chk_rsp("t6_rsp", n, r, o, t, 6'd7, 32'd13, 1'b0, 1'b0);
    tests++;
    if (go_cnt - g0 !== 1) begin
      fails++; $display("FAIL t6_go_count: got %0d pulses, required 1", go_cnt - g0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_timeout();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
